pcs_receive_wide: RTL and testbench

PCS_RECEIVE_WIDE -- requirements
Module: pcs_receive_wide

---
 rtl/pcs_receive_wide_pkg.sv | 28 ++
 rtl/pcs_rx_decoder.sv | 94 +++++++++
 rtl/pcs_receive_wide.sv | 226 ++++++++++++++++++++++
 tb/tb_pcs_receive_wide.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_receive_wide_pkg.sv
// Shared constants for the wide PCS receive path: FSM state encodings and 10b code-groups.
// Code-groups are written abcdei_fghj with bit 'a' as the MSB.
package pcs_receive_wide_pkg;

    localparam logic [2:0] StWaitK   = 3'd0;
    localparam logic [2:0] StRxK     = 3'd1;
    localparam logic [2:0] StIdleD   = 3'd2;
    localparam logic [2:0] StReceive = 3'd3;
    localparam logic [2:0] StTriRr   = 3'd4;
    localparam logic [2:0] StRxErr   = 3'd5;

    localparam logic [9:0] K285Neg = 10'b001111_1010;
    localparam logic [9:0] K285Pos = 10'b110000_0101;
    localparam logic [9:0] K277Neg = 10'b110110_1000;
    localparam logic [9:0] K277Pos = 10'b001001_0111;
    localparam logic [9:0] K297Neg = 10'b101110_1000;
    localparam logic [9:0] K297Pos = 10'b010001_0111;
    localparam logic [9:0] K237Neg = 10'b111010_1000;
    localparam logic [9:0] K237Pos = 10'b000101_0111;

    localparam logic [7:0] Preamble = 8'h55;

    function automatic logic is_code(input logic [9:0] code, input logic [9:0] rd_neg,
                                     input logic [9:0] rd_pos);
        return (code == rd_neg) || (code == rd_pos);
    endfunction

endpackage

// File: rtl/pcs_rx_decoder.sv
// Combinational 10b-to-8b lookup; disparity is not tracked, so either running-disparity form
// of a code-group decodes to the same octet.
module pcs_rx_decoder (
    input  logic [9:0] i_code,
    output logic       o_valid,
    output logic       o_is_k,
    output logic [7:0] o_octet
);

    logic [5:0] w_six;
    logic [3:0] w_four;
    logic [3:0] w_four_adj;
    logic       w_v5;
    logic       w_v3;
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k28;
    logic       w_k7;

    assign w_six  = i_code[9:4];
    assign w_four = i_code[3:0];

    always_comb begin
        w_v5 = 1'b1;
        w_x  = 5'd0;
        case (w_six)
            6'b100111, 6'b011000: w_x = 5'd0;
            6'b011101, 6'b100010: w_x = 5'd1;
            6'b101101, 6'b010010: w_x = 5'd2;
            6'b110001:            w_x = 5'd3;
            6'b110101, 6'b001010: w_x = 5'd4;
            6'b101001:            w_x = 5'd5;
            6'b011001:            w_x = 5'd6;
            6'b111000, 6'b000111: w_x = 5'd7;
            6'b111001, 6'b000110: w_x = 5'd8;
            6'b100101:            w_x = 5'd9;
            6'b010101:            w_x = 5'd10;
            6'b110100:            w_x = 5'd11;
            6'b001101:            w_x = 5'd12;
            6'b101100:            w_x = 5'd13;
            6'b011100:            w_x = 5'd14;
            6'b010111, 6'b101000: w_x = 5'd15;
            6'b011011, 6'b100100: w_x = 5'd16;
            6'b100011:            w_x = 5'd17;
            6'b010011:            w_x = 5'd18;
            6'b110010:            w_x = 5'd19;
            6'b001011:            w_x = 5'd20;
            6'b101010:            w_x = 5'd21;
            6'b011010:            w_x = 5'd22;
            6'b111010, 6'b000101: w_x = 5'd23;
            6'b110011, 6'b001100: w_x = 5'd24;
            6'b100110:            w_x = 5'd25;
            6'b010110:            w_x = 5'd26;
            6'b110110, 6'b001001: w_x = 5'd27;
            6'b001110:            w_x = 5'd28;
            6'b101110, 6'b010001: w_x = 5'd29;
            6'b011110, 6'b100001: w_x = 5'd30;
            6'b101011, 6'b010100: w_x = 5'd31;
            6'b001111, 6'b110000: w_x = 5'd28;
            default:              w_v5 = 1'b0;
        endcase
    end

    // K28 with RD+ carries the complemented 4b code, so fold it back onto the data table.
    assign w_four_adj = (w_six == 6'b110000) ? ~w_four : w_four;

    always_comb begin
        w_v3 = 1'b1;
        w_y  = 3'd0;
        case (w_four_adj)
            4'b1011, 4'b0100:                   w_y = 3'd0;
            4'b1001:                            w_y = 3'd1;
            4'b0101:                            w_y = 3'd2;
            4'b1100, 4'b0011:                   w_y = 3'd3;
            4'b1101, 4'b0010:                   w_y = 3'd4;
            4'b1010:                            w_y = 3'd5;
            4'b0110:                            w_y = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: w_y = 3'd7;
            default:                            w_v3 = 1'b0;
        endcase
    end

    assign w_k28 = (w_six == 6'b001111) || (w_six == 6'b110000);
    assign w_k7  = ((w_six == 6'b111010) || (w_six == 6'b000101) ||
                    (w_six == 6'b110110) || (w_six == 6'b001001) ||
                    (w_six == 6'b101110) || (w_six == 6'b010001) ||
                    (w_six == 6'b011110) || (w_six == 6'b100001)) &&
                   ((w_four == 4'b1000) || (w_four == 4'b0111));

    assign o_valid = w_v5 & w_v3;
    assign o_is_k  = w_k28 | w_k7;
    assign o_octet = {w_y, w_x};

endmodule

// File: rtl/pcs_receive_wide.sv
// PCS receive FSM packing decoded octets into BYTES-wide words.
// Define RX_STATS_EN to add saturating pkt_count/err_count statistics outputs.
module pcs_receive_wide
    import pcs_receive_wide_pkg::*;
#(
    parameter int unsigned BYTES = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          SUDI,
    input  logic                 sync_status,
    output logic [8*BYTES-1:0]   RXD,
    output logic [BYTES-1:0]     RX_BE,
    output logic                 RX_DV,
    output logic                 RX_ER,
`ifdef RX_STATS_EN
    output logic [CNT_W-1:0]     pkt_count,
    output logic [CNT_W-1:0]     err_count,
`endif
    output logic                 receiving
);

    localparam int unsigned PW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [PW-1:0] LastLane = PW'(BYTES - 1);

    if (!(BYTES == 1 || BYTES == 2 || BYTES == 4) || CNT_W == 0) begin : g_param_check
        $error("pcs_receive_wide: unsupported BYTES or CNT_W");
    end

    logic             w_valid;
    logic             w_is_k;
    logic [7:0]       w_octet;
    logic             w_data;
    logic             w_k285;
    logic             w_k277;
    logic             w_k297;
    logic             w_k237;

    pcs_rx_decoder u_decoder (
        .i_code  (SUDI[10:1]),
        .o_valid (w_valid),
        .o_is_k  (w_is_k),
        .o_octet (w_octet)
    );

    assign w_data = w_valid & ~w_is_k;
    assign w_k285 = is_code(SUDI[10:1], K285Neg, K285Pos);
    assign w_k277 = is_code(SUDI[10:1], K277Neg, K277Pos);
    assign w_k297 = is_code(SUDI[10:1], K297Neg, K297Pos);
    assign w_k237 = is_code(SUDI[10:1], K237Neg, K237Pos);

    logic [2:0]         r_state,  w_state_nxt;
    logic [PW-1:0]      r_ptr,    w_ptr_nxt;
    logic [8*BYTES-1:0] r_buf,    w_buf_nxt;
    logic [8*BYTES-1:0] r_rxd,    w_rxd_nxt;
    logic [BYTES-1:0]   r_be,     w_be_nxt;
    logic               r_dv,     w_dv_nxt;
    logic               r_er,     w_er_nxt;
    logic               r_recv,   w_recv_nxt;
    logic               w_acc;
    logic [7:0]         w_acc_oct;
    logic [BYTES-1:0]   w_fill_mask;
    logic [BYTES-1:0]   w_err_mask;

    always_comb begin
        w_fill_mask = '0;
        w_err_mask  = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            w_fill_mask[i] = (i < int'(r_ptr));
            w_err_mask[i]  = (i <= int'(r_ptr));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_buf_nxt   = r_buf;
        w_rxd_nxt   = r_rxd;
        w_be_nxt    = '0;
        w_dv_nxt    = 1'b0;
        w_er_nxt    = 1'b0;
        w_recv_nxt  = r_recv;
        w_acc       = 1'b0;
        w_acc_oct   = w_octet;

        if (!sync_status) begin
            w_state_nxt = StWaitK;
            w_ptr_nxt   = '0;
            w_recv_nxt  = 1'b0;
        end else begin
            case (r_state)
                StWaitK: begin
                    if (w_k285 && SUDI[0]) w_state_nxt = StRxK;
                end
                StRxK: begin
                    w_state_nxt = w_data ? StIdleD : StWaitK;
                end
                StIdleD: begin
                    if (w_k285) begin
                        w_state_nxt = StRxK;
                    end else if (w_k277) begin
                        w_state_nxt = StReceive;
                        w_recv_nxt  = 1'b1;
                        w_acc       = 1'b1;
                        w_acc_oct   = Preamble;
                    end
                end
                StReceive: begin
                    if (w_data) begin
                        w_acc = 1'b1;
                    end else if (w_k297) begin
                        w_state_nxt = StTriRr;
                        w_ptr_nxt   = '0;
                        if (r_ptr != '0) begin
                            w_dv_nxt  = 1'b1;
                            w_be_nxt  = w_fill_mask;
                            w_rxd_nxt = r_buf;
                        end
                    end else if (w_k285) begin
                        // An empty partial word still reports the early end as a lone RX_ER.
                        w_state_nxt = StRxK;
                        w_recv_nxt  = 1'b0;
                        w_ptr_nxt   = '0;
                        w_er_nxt    = 1'b1;
                        if (r_ptr != '0) begin
                            w_dv_nxt  = 1'b1;
                            w_be_nxt  = w_fill_mask;
                            w_rxd_nxt = r_buf;
                        end
                    end else begin
                        w_buf_nxt[int'(r_ptr)*8 +: 8] = 8'h00;
                        w_state_nxt = StRxErr;
                        w_recv_nxt  = 1'b0;
                        w_ptr_nxt   = '0;
                        w_dv_nxt    = 1'b1;
                        w_er_nxt    = 1'b1;
                        w_be_nxt    = w_err_mask;
                        w_rxd_nxt   = w_buf_nxt;
                    end
                end
                StTriRr: begin
                    if (w_k285) begin
                        w_state_nxt = StRxK;
                        w_recv_nxt  = 1'b0;
                    end else if (!w_k237) begin
                        w_state_nxt = StRxErr;
                        w_recv_nxt  = 1'b0;
                        w_er_nxt    = 1'b1;
                    end
                end
                StRxErr: begin
                    w_recv_nxt = 1'b0;
                    if (w_k285) w_state_nxt = StRxK;
                end
                default: begin
                    w_state_nxt = StWaitK;
                    w_recv_nxt  = 1'b0;
                    w_ptr_nxt   = '0;
                end
            endcase

            if (w_acc) begin
                w_buf_nxt[int'(r_ptr)*8 +: 8] = w_acc_oct;
                if (r_ptr == LastLane) begin
                    w_ptr_nxt = '0;
                    w_dv_nxt  = 1'b1;
                    w_be_nxt  = '1;
                    w_rxd_nxt = w_buf_nxt;
                end else begin
                    w_ptr_nxt = r_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StWaitK;
            r_ptr   <= '0;
            r_buf   <= '0;
            r_rxd   <= '0;
            r_be    <= '0;
            r_dv    <= 1'b0;
            r_er    <= 1'b0;
            r_recv  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_buf   <= w_buf_nxt;
            r_rxd   <= w_rxd_nxt;
            r_be    <= w_be_nxt;
            r_dv    <= w_dv_nxt;
            r_er    <= w_er_nxt;
            r_recv  <= w_recv_nxt;
        end
    end

    assign RXD       = r_rxd;
    assign RX_BE     = r_be;
    assign RX_DV     = r_dv;
    assign RX_ER     = r_er;
    assign receiving = r_recv;

`ifdef RX_STATS_EN
    logic             w_pkt_inc;
    logic [CNT_W-1:0] r_pkt;
    logic [CNT_W-1:0] r_err;

    assign w_pkt_inc = sync_status && (r_state == StReceive) && w_k297;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt <= '0;
            r_err <= '0;
        end else begin
            if (w_pkt_inc && !(&r_pkt)) r_pkt <= r_pkt + CNT_W'(1);
            if (r_er && !(&r_err))      r_err <= r_err + CNT_W'(1);
        end
    end

    assign pkt_count = r_pkt;
    assign err_count = r_err;
`endif

endmodule

// File: tb/tb_pcs_receive_wide.sv
// Scoreboard bench driving three pcs_receive_wide instances (BYTES = 2, 4, 1) with directed
// code-group sequences; counters are checked when RX_STATS_EN is defined.
module tb_pcs_receive_wide;

    localparam logic [9:0] K285N = 10'b001111_1010;
    localparam logic [9:0] K285P = 10'b110000_0101;
    localparam logic [9:0] CS    = 10'b110110_1000;
    localparam logic [9:0] CT    = 10'b101110_1000;
    localparam logic [9:0] CR    = 10'b111010_1000;
    localparam logic [9:0] D215  = 10'b101010_1010;
    localparam logic [9:0] D000  = 10'b100111_0100;
    localparam logic [9:0] D010  = 10'b011101_0100;
    localparam logic [9:0] D020  = 10'b101101_0100;
    localparam logic [9:0] BAD   = 10'b000000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] sudi   [3];
    logic        sync_s [3];
    logic        rst_s  [3];

    logic [15:0] rxd_a;
    logic [1:0]  be_a;
    logic        dv_a, er_a, recv_a;
    logic [31:0] rxd_b;
    logic [3:0]  be_b;
    logic        dv_b, er_b, recv_b;
    logic [7:0]  rxd_c;
    logic [0:0]  be_c;
    logic        dv_c, er_c, recv_c;
`ifdef RX_STATS_EN
    logic [15:0] pkt_a, err_a, pkt_b, err_b, pkt_c, err_c;
`endif

    pcs_receive_wide #(.BYTES(2)) u_dut_a (
        .clk(clk), .reset(rst_s[0]), .SUDI(sudi[0]), .sync_status(sync_s[0]),
        .RXD(rxd_a), .RX_BE(be_a), .RX_DV(dv_a), .RX_ER(er_a),
`ifdef RX_STATS_EN
        .pkt_count(pkt_a), .err_count(err_a),
`endif
        .receiving(recv_a)
    );

    pcs_receive_wide #(.BYTES(4)) u_dut_b (
        .clk(clk), .reset(rst_s[1]), .SUDI(sudi[1]), .sync_status(sync_s[1]),
        .RXD(rxd_b), .RX_BE(be_b), .RX_DV(dv_b), .RX_ER(er_b),
`ifdef RX_STATS_EN
        .pkt_count(pkt_b), .err_count(err_b),
`endif
        .receiving(recv_b)
    );

    pcs_receive_wide #(.BYTES(1)) u_dut_c (
        .clk(clk), .reset(rst_s[2]), .SUDI(sudi[2]), .sync_status(sync_s[2]),
        .RXD(rxd_c), .RX_BE(be_c), .RX_DV(dv_c), .RX_ER(er_c),
`ifdef RX_STATS_EN
        .pkt_count(pkt_c), .err_count(err_c),
`endif
        .receiving(recv_c)
    );

    typedef struct {
        logic        dv;
        logic [31:0] d;
        logic [3:0]  be;
        logic        er;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic push(input int k, input logic dv, input logic [31:0] d, input logic [3:0] be,
                        input logic er);
        exp_t e;
        e.dv = dv;
        e.d  = d;
        e.be = be;
        e.er = er;
        case (k)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic dv, input logic [31:0] d, input logic [3:0] be,
                       input logic er);
        exp_t        e;
        logic        got;
        logic [31:0] m;
        got = 1'b0;
        case (k)
            0:       if (q_a.size() != 0) begin e = q_a.pop_front(); got = 1'b1; end
            1:       if (q_b.size() != 0) begin e = q_b.pop_front(); got = 1'b1; end
            default: if (q_c.size() != 0) begin e = q_c.pop_front(); got = 1'b1; end
        endcase
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL out%0d unexpected: dv=%b rxd=%h be=%b er=%b", k, dv, d, be, er);
        end else begin
            m = '0;
            for (int i = 0; i < 4; i++) if (e.be[i]) m[8*i +: 8] = 8'hff;
            if (dv !== e.dv || be !== e.be || er !== e.er || (d & m) !== (e.d & m)) begin
                n_fail++;
                $display("FAIL out%0d word: got dv=%b rxd=%h be=%b er=%b, expected dv=%b rxd=%h be=%b er=%b",
                         k, dv, d & m, be, er, e.dv, e.d & m, e.be, e.er);
            end
        end
    endtask

    always @(negedge clk) if (dv_a || er_a) mon(0, dv_a, {16'h0, rxd_a}, {2'b00, be_a}, er_a);
    always @(negedge clk) if (dv_b || er_b) mon(1, dv_b, rxd_b, be_b, er_b);
    always @(negedge clk) if (dv_c || er_c) mon(2, dv_c, {24'h0, rxd_c}, {3'b000, be_c}, er_c);

    task automatic step(input int k, input logic [9:0] c);
        sudi[k] = {c, 1'b1};
        @(posedge clk);
        #1;
    endtask

    task automatic lock(input int k);
        step(k, K285N);
        step(k, D215);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            sudi[k]   = '0;
            sync_s[k] = 1'b1;
            rst_s[k]  = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {rxd_a, be_a, dv_a, er_a, recv_a}, 0);
        chk("reset_b", {rxd_b, be_b, dv_b, er_b, recv_b}, 0);
        chk("reset_c", {rxd_c, be_c, dv_c, er_c, recv_c}, 0);
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;

        // BYTES=2: full words, /T/ on a word boundary, /R/ hold
        lock(0);
        step(0, CS);
        chk("a_recv_on_s", recv_a, 1);
        push(0, 1, 32'h0055, 4'b0011, 0); step(0, D000);
        step(0, D010);
        push(0, 1, 32'h0201, 4'b0011, 0); step(0, D020);
        step(0, CT);
        step(0, CR);
        chk("a_recv_in_tri_rr", recv_a, 1);
        step(0, K285P);
        chk("a_recv_after_idle", recv_a, 0);
        step(0, D215);

        // odd trailing octet
        step(0, CS);
        push(0, 1, 32'h0055, 4'b0011, 0); step(0, D000);
        step(0, D010);
        push(0, 1, 32'h0001, 4'b0001, 0); step(0, CT);
        step(0, K285N);
        step(0, D215);

        // unexpected K inside a packet
        step(0, CS);
        push(0, 1, 32'hB555, 4'b0011, 0); step(0, D215);
        push(0, 1, 32'h0000, 4'b0001, 1); step(0, CR);
        chk("c_recv_after_err", recv_a, 0);
        step(0, CS);
        chk("c_no_start_in_rx_err", recv_a, 0);
        step(0, K285N);
        step(0, D215);

        // early end with K28.5
        step(0, CS);
        push(0, 1, 32'h0055, 4'b0011, 0); step(0, D000);
        step(0, D010);
        push(0, 1, 32'h0001, 4'b0001, 1); step(0, K285P);
        chk("d_recv_early_end", recv_a, 0);
        step(0, D215);
        step(0, CS);
        chk("d_restart", recv_a, 1);

        // sync loss mid-packet, then relock rules
        push(0, 1, 32'h0155, 4'b0011, 0); step(0, D010);
        step(0, D000);
        sync_s[0] = 1'b0;
        step(0, D020);
        sync_s[0] = 1'b1;
        chk("e_recv_sync_drop", recv_a, 0);
        step(0, D215);
        step(0, CS);
        chk("e_no_relock_without_k", recv_a, 0);
        sudi[0] = {K285N, 1'b0};
        @(posedge clk);
        #1;
        step(0, D215);
        step(0, CS);
        chk("e_no_relock_odd_k", recv_a, 0);
        lock(0);
        step(0, CS);
        chk("e_relock", recv_a, 1);
        push(0, 1, 32'h0055, 4'b0011, 0); step(0, D000);
        step(0, CT);
        step(0, K285N);

        // BYTES=4: invalid code after two octets of the second word
        lock(1);
        step(1, CS);
        step(1, D000);
        step(1, D010);
        push(1, 1, 32'h0201_0055, 4'b1111, 0); step(1, D020);
        step(1, D215);
        step(1, D010);
        push(1, 1, 32'h0000_01B5, 4'b0111, 1); step(1, BAD);
        chk("f_recv_after_bad", recv_b, 0);
        step(1, D215);
        step(1, CS);
        chk("f_hold_rx_err", recv_b, 0);
        step(1, K285N);
        step(1, D215);
        step(1, CS);
        chk("f_recover", recv_b, 1);
        step(1, D000);
        step(1, D010);
        push(1, 1, 32'h0001_0055, 4'b0111, 0); step(1, CT);
        step(1, K285N);
        step(1, D215);
        // reset with octets buffered must leave no residue
        step(1, CS);
        step(1, D000);
        rst_s[1] = 1'b1;
        step(1, D010);
        chk("f_reset_mid", {rxd_b, be_b, dv_b, er_b, recv_b}, 0);
        rst_s[1] = 1'b0;
        lock(1);
        step(1, CS);
        step(1, D000);
        step(1, D010);
        push(1, 1, 32'h0201_0055, 4'b1111, 0); step(1, D020);
        step(1, CT);
        step(1, K285N);

        // BYTES=1: three good packets and one early end
        lock(2);
        for (int p = 0; p < 3; p++) begin
            push(2, 1, 32'h55, 4'b0001, 0); step(2, CS);
            push(2, 1, 32'h00, 4'b0001, 0); step(2, D000);
            push(2, 1, 32'hB5, 4'b0001, 0); step(2, D215);
            step(2, CT);
            step(2, K285N);
            step(2, D215);
        end
        push(2, 1, 32'h55, 4'b0001, 0); step(2, CS);
        push(2, 1, 32'h01, 4'b0001, 0); step(2, D010);
        push(2, 0, 32'h00, 4'b0000, 1); step(2, K285P);
        chk("g_recv_early_end", recv_c, 0);
        step(2, D215);
`ifdef RX_STATS_EN
        chk("g_pkt_count", pkt_c, 3);
        chk("g_err_count", err_c, 1);
        chk("a_pkt_count", pkt_a, 3);
        chk("a_err_count", err_a, 2);
        chk("b_pkt_count", pkt_b, 1);
`endif
        push(2, 1, 32'h55, 4'b0001, 0); step(2, CS);
        rst_s[2] = 1'b1;
        step(2, D000);
        chk("g_reset_mid", {rxd_c, be_c, dv_c, er_c, recv_c}, 0);
`ifdef RX_STATS_EN
        chk("g_reset_counters", {pkt_c, err_c}, 0);
`endif
        rst_s[2] = 1'b0;
        step(2, D000);
        step(2, CS);
        chk("g_idle_after_reset", recv_c, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        chk("drain_c", q_c.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
